// File: rtl/recognition_uart_reporter.sv
// recognition_uart_reporter: queues recognition/training events and sends each as a 4-byte 8N1 UART message
module recognition_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] recognition_result,
  input  logic       recognition_result_flag,
  input  logic       train_down,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       event_dropped
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic M_IDLE = 1'b0;
  localparam logic M_SEND = 1'b1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] STOP = 2'd3;

  logic          train_q, rec_pend_q, rec_pend_d, trn_pend_q, trn_pend_d;
  logic          drop_q, drop_d, tx_q, tx_d, m_q, m_d, msg_rec_q, msg_rec_d;
  logic [2:0]    rec_res_q, rec_res_d, msg_res_q, msg_res_d, bit_q, bit_d;
  logic [1:0]    b_q, b_d, byte_q, byte_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tr_edge, load, load_rec, cnt_end;
  logic [7:0]    cur_byte;

  always_comb begin
    tr_edge    = train_down & ~train_q;
    load       = (m_q == M_IDLE) && (rec_pend_q || trn_pend_q);
    load_rec   = load & rec_pend_q;
    cnt_end    = cnt_q == CW'(CLKS_PER_BIT - 1);
    // Latest recognition result wins; an unsent one being replaced is reported as dropped.
    rec_pend_d = recognition_result_flag | (rec_pend_q & ~load_rec);
    rec_res_d  = recognition_result_flag ? recognition_result : rec_res_q;
    drop_d     = recognition_result_flag & rec_pend_q & ~load_rec;
    trn_pend_d = tr_edge | (trn_pend_q & ~(load & ~rec_pend_q));
    cur_byte   = byte_q == 2'd0 ? (msg_rec_q ? 8'h52 : 8'h54) :
                 byte_q == 2'd1 ? (msg_rec_q ? {5'b00110, msg_res_q} : 8'h44) :
                 byte_q == 2'd2 ? 8'h0D : 8'h0A;
    // The line is registered from the current bit state, so it trails b_q by one cycle.
    tx_d       = b_q == START ? 1'b0 : b_q == DATA ? cur_byte[bit_q] : 1'b1;
    cnt_d      = (b_q == IDLE || cnt_end) ? '0 : cnt_q + 1'b1;
    m_d        = m_q;
    b_d        = b_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    msg_rec_d  = msg_rec_q;
    msg_res_d  = msg_res_q;
    if (load) begin
      m_d       = M_SEND;
      b_d       = START;
      msg_rec_d = rec_pend_q;
      msg_res_d = rec_res_q;
    end else if (b_q != IDLE && cnt_end) begin
      case (b_q)
        START:   b_d = DATA;
        DATA: begin
          bit_d = bit_q + 3'd1;
          b_d   = bit_q == 3'd7 ? STOP : DATA;
        end
        default: begin
          byte_d = byte_q + 2'd1;
          b_d    = byte_q == 2'd3 ? IDLE : START;
          m_d    = byte_q == 2'd3 ? M_IDLE : M_SEND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      train_q    <= 1'b0;
      rec_pend_q <= 1'b0;
      trn_pend_q <= 1'b0;
      rec_res_q  <= '0;
      drop_q     <= 1'b0;
      tx_q       <= 1'b1;
      m_q        <= M_IDLE;
      b_q        <= IDLE;
      byte_q     <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      msg_rec_q  <= 1'b0;
      msg_res_q  <= '0;
    end else begin
      train_q    <= train_down;
      rec_pend_q <= rec_pend_d;
      trn_pend_q <= trn_pend_d;
      rec_res_q  <= rec_res_d;
      drop_q     <= drop_d;
      tx_q       <= tx_d;
      m_q        <= m_d;
      b_q        <= b_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      msg_rec_q  <= msg_rec_d;
      msg_res_q  <= msg_res_d;
    end
  end

  assign rs232_tx      = tx_q;
  assign tx_busy       = m_q == M_SEND;
  assign event_dropped = drop_q;
endmodule

// File: tb/tb_recognition_uart_reporter.sv
// tb_recognition_uart_reporter: directed vectors plus multi-cycle sequences, decoded from a per-cycle line log
module tb_recognition_uart_reporter;
  localparam int LOGN = 16384;
  localparam int MSG = 320;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] recognition_result = '0;
  logic       recognition_result_flag = 1'b0;
  logic       train_down = 1'b0;
  logic       rs232_tx, tx_busy, event_dropped;

  logic txl [LOGN];
  logic bzl [LOGN];
  logic dpl [LOGN];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [2:0] res;
    logic [7:0] exp1;
  } vec_t;
  vec_t vecs [8];

  recognition_uart_reporter #(.CLKS_PER_BIT(8)) dut (
    .clk(clk),
    .rst(rst),
    .recognition_result(recognition_result),
    .recognition_result_flag(recognition_result_flag),
    .train_down(train_down),
    .rs232_tx(rs232_tx),
    .tx_busy(tx_busy),
    .event_dropped(event_dropped)
  );

  always #5 clk = ~clk;

  // Entry i holds the outputs just after the i-th logged rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (cyc < LOGN) begin
      txl[cyc] = rs232_tx;
      bzl[cyc] = tx_busy;
      dpl[cyc] = event_dropped;
    end
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int find_low(input int a, input int b);
    for (int i = a; i < b; i++) if (!txl[i]) return i;
    return -1;
  endfunction

  function automatic int frame(input int f);
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = txl[f + 8 * i + 4];
    return int'(v);
  endfunction

  function automatic int count(input bit drop, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) n += drop ? int'(dpl[i]) : int'(bzl[i]);
    return n;
  endfunction

  task automatic chk_msg(input string tag, input int s, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e [4];
    e = '{b0, b1, b2, b3};
    for (int i = 0; i < 4; i++)
      check($sformatf("%s frame%0d", tag, i), frame(s + 80 * i), int'({1'b1, e[i], 1'b0}));
  endtask

  task automatic pulse(input logic [2:0] r);
    recognition_result = r;
    recognition_result_flag = 1'b1;
    tick(1);
    recognition_result_flag = 1'b0;
    recognition_result = ~r;
  endtask

  initial begin
    int c, s, c2;
    vecs[0] = '{3'd0, 8'h30};
    vecs[1] = '{3'd1, 8'h31};
    vecs[2] = '{3'd2, 8'h32};
    vecs[3] = '{3'd3, 8'h33};
    vecs[4] = '{3'd4, 8'h34};
    vecs[5] = '{3'd5, 8'h35};
    vecs[6] = '{3'd6, 8'h36};
    vecs[7] = '{3'd7, 8'h37};

    tick(5);
    check("reset tx", int'(rs232_tx), 1);
    check("reset busy", int'(tx_busy), 0);
    check("reset drop", int'(event_dropped), 0);
    rst = 1'b0;
    c = cyc;
    tick(100);
    check("idle no start", find_low(c, c + 100), -1);
    check("idle busy", count(0, c, c + 100), 0);

    foreach (vecs[v]) begin
      c = cyc;
      pulse(vecs[v].res);
      tick(339);
      s = c + 2;
      check($sformatf("rec%0d latency", v), find_low(c, c + 330), s);
      chk_msg($sformatf("rec%0d", v), s, 8'h52, vecs[v].exp1, 8'h0D, 8'h0A);
      check($sformatf("rec%0d busy", v), count(0, c, c + 339), MSG);
      check($sformatf("rec%0d busy start", v), int'(bzl[c + 1]), 1);
      check($sformatf("rec%0d drop", v), count(1, c, c + 339), 0);
    end

    c = cyc;
    train_down = 1'b1;
    tick(1000);
    s = c + 2;
    check("train latency", find_low(c, c + 330), s);
    chk_msg("train", s, 8'h54, 8'h44, 8'h0D, 8'h0A);
    check("train single", find_low(s + MSG, c + 1000), -1);
    check("train drop", count(1, c, c + 1000), 0);
    train_down = 1'b0;
    tick(5);

    c = cyc;
    pulse(3'd2);
    tick(49);
    pulse(3'd5);
    tick(10);
    pulse(3'd6);
    tick(700 - 62);
    s = c + 2;
    chk_msg("drop first", s, 8'h52, 8'h32, 8'h0D, 8'h0A);
    check("drop gap", find_low(s + MSG, c + 700), s + MSG + 1);
    chk_msg("drop second", s + MSG + 1, 8'h52, 8'h36, 8'h0D, 8'h0A);
    check("drop pulses", count(1, c, c + 700), 1);
    check("drop busy", count(0, c, c + 700), 2 * MSG);
    check("drop busy gap", int'(bzl[s + MSG - 1]), 0);

    c = cyc;
    recognition_result = 3'd1;
    recognition_result_flag = 1'b1;
    train_down = 1'b1;
    tick(1);
    recognition_result_flag = 1'b0;
    tick(700);
    s = c + 2;
    check("both latency", find_low(c, c + 330), s);
    chk_msg("both rec", s, 8'h52, 8'h31, 8'h0D, 8'h0A);
    check("both gap", find_low(s + MSG, c + 700), s + MSG + 1);
    chk_msg("both train", s + MSG + 1, 8'h54, 8'h44, 8'h0D, 8'h0A);
    check("both drop", count(1, c, c + 700), 0);
    train_down = 1'b0;
    tick(5);

    c = cyc;
    pulse(3'd4);
    tick(124);
    s = c + 2;
    check("midrst started", find_low(c, c + 10), s);
    check("midrst byte0", frame(s), int'({1'b1, 8'h52, 1'b0}));
    check("midrst busy before", int'(tx_busy), 1);
    rst = 1'b1;
    #1;
    check("midrst tx async", int'(rs232_tx), 1);
    check("midrst busy async", int'(tx_busy), 0);
    tick(3);
    rst = 1'b0;
    c2 = cyc;
    tick(400);
    check("midrst no resume", find_low(c2, c2 + 400), -1);
    check("midrst busy after", count(0, c2, c2 + 400), 0);

    rst = 1'b1;
    train_down = 1'b1;
    tick(3);
    rst = 1'b0;
    c = cyc;
    tick(340);
    check("relhigh latency", find_low(c, c + 330), c + 2);
    chk_msg("relhigh", c + 2, 8'h54, 8'h44, 8'h0D, 8'h0A);
    train_down = 1'b0;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
